// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller: samples V and I on a shared ADC, computes P = V*I, and nudges the PWM duty.
// Optional macro MPPT_ADAPTIVE_STEP_EN enables a 4x step when |power - prev_power| > 1024.
module mppt_po_controller #(
  parameter int unsigned DUTY_INIT     = 128,
  parameter int unsigned DUTY_MIN      = 16,
  parameter int unsigned DUTY_MAX      = 240,
  parameter int unsigned STEP          = 2,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned ADC_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_req,
  output logic        adc_sel,
  input  logic        adc_valid,
  input  logic [7:0]  adc_data,
  output logic [7:0]  duty,
  output logic        duty_upd,
  output logic [15:0] power,
  output logic        dir,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [3:0] {
    IDLE, REQ_V, WAIT_V, REQ_I, WAIT_I, COMPUTE, DECIDE, PERTURB, SETTLE
  } state_t;

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ADC_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      prev_power;
  logic [7:0]       v_q;
  logic [7:0]       i_q;
  logic [8:0]       step9;

`ifdef MPPT_ADAPTIVE_STEP_EN
  logic        big_step;
  logic [15:0] delta;

  always_comb begin
    delta = (power > prev_power) ? (power - prev_power) : (prev_power - power);
  end

  always_ff @(posedge clk) begin
    if (rst)
      big_step <= 1'b0;
    else if (state == DECIDE)
      big_step <= (delta > 16'd1024);
  end

  assign step9 = big_step ? 9'(4 * STEP) : 9'(STEP);
`else
  assign step9 = 9'(STEP);
`endif

  // 9-bit arithmetic so a step past either rail never wraps through 0/255.
  logic [8:0] duty9;
  logic [8:0] up_sum;
  logic [8:0] dn_diff;
  logic       up_hit;
  logic       dn_hit;
  logic [7:0] next_duty;
  logic       clamp_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_duty = duty;
    clamp_hit = 1'b0;
    duty9     = {1'b0, duty};
    up_sum    = duty9 + step9;
    dn_diff   = duty9 - step9;
    up_hit    = (up_sum >= 9'(DUTY_MAX));
    dn_hit    = (duty9 <= 9'(DUTY_MIN) + step9);
    if (dir) begin
      next_duty = up_hit ? 8'(DUTY_MAX) : up_sum[7:0];
      clamp_hit = up_hit;
    end else begin
      next_duty = dn_hit ? 8'(DUTY_MIN) : dn_diff[7:0];
      clamp_hit = dn_hit;
    end
  end

  // NOTE: pure datapath captures carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (adc_valid && state == WAIT_V) v_q <= adc_data;
    if (adc_valid && state == WAIT_I) i_q <= adc_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      duty       <= 8'(DUTY_INIT);
      dir        <= 1'b1;
      power      <= '0;
      prev_power <= '0;
      adc_req    <= 1'b0;
      adc_sel    <= 1'b0;
      duty_upd   <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      adc_req  <= 1'b0;
      duty_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fault) begin
            state   <= REQ_V;
            adc_req <= 1'b1;
            adc_sel <= 1'b0;
            busy    <= 1'b1;
          end
        end
        REQ_V: begin
          state <= WAIT_V;
          cnt   <= '0;
        end
        WAIT_V: begin
          if (adc_valid) begin
            state   <= REQ_I;
            adc_req <= 1'b1;
            adc_sel <= 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ_I: begin
          state <= WAIT_I;
          cnt   <= '0;
        end
        WAIT_I: begin
          if (adc_valid) begin
            state <= COMPUTE;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMPUTE: begin
          power <= {8'd0, v_q} * {8'd0, i_q};
          state <= DECIDE;
        end
        DECIDE: begin
          if (power < prev_power) dir <= ~dir;
          prev_power <= power;
          state      <= PERTURB;
        end
        PERTURB: begin
          duty     <= next_duty;
          duty_upd <= (next_duty != duty);
          if (clamp_hit) dir <= ~dir;
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Scoreboard bench for mppt_po_controller: each iteration pushes its expected duty/dir/power,
// and a monitor pops and compares on every duty_upd pulse.
module tb_mppt_po_controller;

  localparam int unsigned SETTLE = 20;
`ifdef MPPT_ADAPTIVE_STEP_EN
  localparam int FIRST_STEP = 8;
`else
  localparam int FIRST_STEP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_req;
  logic        adc_sel;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic [7:0]  duty;
  logic        duty_upd;
  logic [15:0] power;
  logic        dir;
  logic        busy;
  logic        fault;

  mppt_po_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .adc_req   (adc_req),
    .adc_sel   (adc_sel),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .duty      (duty),
    .duty_upd  (duty_upd),
    .power     (power),
    .dir       (dir),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  duty;
    logic        dir;
    logic [15:0] power;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares against the scoreboard whenever the DUT reports a duty change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && adc_req) req_count++;
      if (!rst && duty_upd) begin
        if (exp_q.size() == 0) begin
          check("unexpected duty_upd", 32'(duty), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("duty", 32'(duty), 32'(e.duty));
          check("dir", 32'(dir), 32'(e.dir));
          check("power", 32'(power), 32'(e.power));
        end
      end
    end
  end

  // Waits for a conversion request, checks its channel, optionally returns data 2 cycles later.
  task automatic adc_respond(input logic sel, input logic [7:0] d, input bit send);
    int t = 0;
    while (!adc_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!adc_req) begin
      check("adc_req timeout", 32'(t), 32'd0);
      return;
    end
    check("adc_sel at req", 32'(adc_sel), 32'(sel));
    if (!send) return;
    repeat (2) @(negedge clk);
    check("adc_sel held", 32'(adc_sel), 32'(sel));
    adc_valid = 1'b1;
    adc_data  = d;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic iteration(input logic [7:0] v, input logic [7:0] i,
                           input logic [7:0] exp_duty, input logic exp_dir);
    exp_t e;
    e.duty  = exp_duty;
    e.dir   = exp_dir;
    e.power = 16'(v) * 16'(i);
    exp_q.push_back(e);
    adc_respond(1'b0, v, 1'b1);
    adc_respond(1'b1, i, 1'b1);
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!duty_upd && n < 200);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " duty"}, 32'(duty), 32'd128);
    check({tag, " dir"}, 32'(dir), 32'd1);
    check({tag, " power"}, 32'(power), 32'd0);
    check({tag, " busy/fault/req/upd"}, {28'd0, busy, fault, adc_req, duty_upd}, 32'd0);
  endtask

  initial begin
    int n;
    int req_before;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle disabled");

    // Iteration 1: 150*40 = 6000 > 0 keeps dir=1.
    enable = 1'b1;
    iteration(8'd150, 8'd40, 8'(128 + FIRST_STEP), 1'b1);
    wait_upd(n);
    check("valid-to-duty latency", 32'(n), 32'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("settle length", 32'(n), 32'(SETTLE));

    // Iteration 2: 4500 < 6000 flips dir down to 128.
    iteration(8'd150, 8'd30, 8'd128, 1'b0);
    wait_upd(n);
    // Iteration 3: 4350 < 4500 flips dir back up.
    iteration(8'd150, 8'd29, 8'd130, 1'b1);
    wait_upd(n);

    // Rising power walks duty up to the 240 rail; reaching the rail flips dir.
    for (int k = 0; k <= 54; k++) begin
      iteration(8'd100, 8'(45 + k), 8'(132 + 2 * k), (k == 54) ? 1'b0 : 1'b1);
      wait_upd(n);
    end

    // Drop enable during SETTLE: iteration completes, no new request follows.
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy low after disable", 32'(busy), 32'd0);
    req_before = req_count;
    adc_valid = 1'b1;
    adc_data  = 8'd77;
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("no req while disabled", 32'(req_count - req_before), 32'd0);
    check("stray valid ignored", {23'd0, busy, duty}, {23'd0, 1'b0, 8'd240});

    enable = 1'b1;
    @(negedge clk);
    check("req right after enable", 32'(adc_req), 32'd1);
    // Power keeps rising with dir=0 after the clamp: 240 -> 238.
    iteration(8'd100, 8'd101, 8'd238, 1'b0);
    wait_upd(n);

    // Withhold the current sample: fault after 255 WAIT_I cycles.
    adc_respond(1'b0, 8'd100, 1'b1);
    adc_respond(1'b1, 8'd0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fault && n < 400);
    check("fault timing", 32'(n), 32'd256);
    check("fault state", {22'd0, fault, busy, duty}, {22'd0, 1'b1, 1'b0, 8'd238});
    req_before = req_count;
    repeat (20) @(negedge clk);
    check("no req after fault", 32'(req_count - req_before), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    check_reset_state("post-fault reset");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
